pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32IM pipeline.
- Drives the hold and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers from four sources: memory busy-waits, taken branches/jumps resolved in EX, load-use hazards, and multi-cycle MUL/DIV operations.
- Owns the MDU start handshake and exposes saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high.
- RS1_ID  in  5  rs1 of the instruction in ID.
- RS2_ID  in  5  rs2 of the instruction in ID.
- RS1_USE_ID  in  1  ID instruction reads rs1.
- RS2_USE_ID  in  1  ID instruction reads rs2.
- RD_IDEX  in  5  rd of the instruction in EX.
- MEMREAD_IDEX  in  1  EX instruction is a load.
- BRANCH_TAKEN_EX  in  1  EX redirects the PC.
- MDU_OP_IDEX  in  1  EX instruction is a MUL/DIV.
- MDU_DONE  in  1  MDU result valid; 1-cycle pulse.
- MEM_BUSYWAIT  in  1  data memory busy.
- IMEM_BUSYWAIT  in  1  instruction memory busy.
- PC_HOLD  out  1  freeze PC.
- IFID_HOLD  out  1  freeze IF/ID.
- IFID_FLUSH  out  1  load NOP into IF/ID.
- IDEX_HOLD  out  1  freeze ID/EX.
- IDEX_FLUSH  out  1  load NOP into ID/EX (bubble).
- EXMEM_BUBBLE  out  1  load NOP into EX/MEM.
- MDU_START  out  1  1-cycle MDU launch pulse.
- STALL_CNT  out  CNT_W  cycles with PC_HOLD=1.
- FLUSH_CNT  out  CNT_W  cycles with IFID_FLUSH=1.

Behaviour:
- Reset (async, immediate): FSM=RUN, MDU_START=0, counters=0. Hold/flush outputs are combinational from state; in RUN with no hazards all are 0.
- FSM states: RUN, MDU_WAIT. State is registered; all outputs are combinational from state and current inputs, so they act on the same edge.
- Priority per cycle, highest first:
  1. Global freeze: MEM_BUSYWAIT or IMEM_BUSYWAIT high → PC_HOLD=IFID_HOLD=IDEX_HOLD=1; every other output 0; FSM holds. A BRANCH_TAKEN_EX or hazard that is present stays present, because the pipe is frozen. It is serviced on the first cycle both busy-waits are low; no pending register is kept.
  2. Branch (RUN only): BRANCH_TAKEN_EX=1 → IFID_FLUSH=IDEX_FLUSH=1, all holds 0. A simultaneous load-use hazard is discarded, since the dependent instruction is being flushed.
  3. MDU: in RUN with MDU_OP_IDEX=1 → MDU_START=1 for exactly that cycle; next state MDU_WAIT; PC/IFID/IDEX held and EXMEM_BUBBLE=1 in the same cycle.
     - In MDU_WAIT: PC_HOLD=IFID_HOLD=IDEX_HOLD=1, EXMEM_BUBBLE=1, MDU_START=0.
     - On MDU_DONE=1: all holds 0 and EXMEM_BUBBLE=0 that cycle, so the result advances; next state RUN.
     - MDU_DONE in RUN is ignored.
     - BRANCH_TAKEN_EX in MDU_WAIT is illegal (the EX slot holds the MDU op) and is ignored.
     - On the RUN cycle after DONE, MDU_OP_IDEX must not retrigger. The ID/EX register advanced on the DONE edge, so the new EX instruction is distinct.
  4. Load-use (RUN only): MEMREAD_IDEX=1, RD_IDEX≠0, and ((RS1_USE_ID and RS1_ID==RD_IDEX) or (RS2_USE_ID and RS2_ID==RD_IDEX)) → PC_HOLD=IFID_HOLD=1, IDEX_FLUSH=1 for exactly one cycle. The next cycle has the load in MEM, so there is no self-sustaining stall.
- rd=x0 never creates a hazard.
- Counters increment on posedge and saturate at all-ones; there is no wrap.
  - STALL_CNT counts cycles with PC_HOLD=1, including global freezes.
  - FLUSH_CNT counts cycles with IFID_FLUSH=1.
- Reset asserted in MDU_WAIT: immediately RUN, holds released, MDU_START=0. The MDU is reset by the same RESET.

Decomposition:
- Shared package: FSM state encoding (RUN=0, MDU_WAIT=1) and the NOP/zero-instruction constant used by the pipeline registers.
- One sub-module: sat_counter (parameter CNT_W; inputs CLK, RESET, INC; output COUNT), instantiated twice.

Test Plan:
- Load-use: MEMREAD_IDEX=1, RD_IDEX=5, RS1_ID=5, RS1_USE_ID=1 → one cycle of PC_HOLD=IFID_HOLD=IDEX_FLUSH=1, then all 0; STALL_CNT=1.
- x0 and unused operands: RD_IDEX=0, or RS2_ID match with RS2_USE_ID=0 → no stall.
- Branch plus load-use in the same cycle → IFID_FLUSH=IDEX_FLUSH=1, PC_HOLD=0; FLUSH_CNT=1.
- MDU: MDU_OP_IDEX=1, MDU_DONE after 8 cycles → MDU_START high 1 cycle; holds and EXMEM_BUBBLE high 9 cycles total, released on the DONE cycle; STALL_CNT=9.
- MEM_BUSYWAIT high 3 cycles with BRANCH_TAKEN_EX=1 → holds for 3 cycles with no flush, then a flush on cycle 4.
- RESET pulse mid-MDU_WAIT → all holds 0 asynchronously and FSM=RUN. Separately, force STALL_CNT to all-ones with CNT_W=4 → stays 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// the instruction loaded by the pipeline registers on a flush.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  // addi x0, x0, 0 -- the canonical RV32I NOP
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             INC,
  output logic [CNT_W-1:0] COUNT
);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      COUNT <= '0;
    else if (INC && (COUNT != {CNT_W{1'b1}}))
      COUNT <= COUNT + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freezes, EX
// redirects, MUL/DIV waits and load-use bubbles, plus perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             RS1_USE_ID,
  input  logic             RS2_USE_ID,
  input  logic [4:0]       RD_IDEX,
  input  logic             MEMREAD_IDEX,
  input  logic             BRANCH_TAKEN_EX,
  input  logic             MDU_OP_IDEX,
  input  logic             MDU_DONE,
  input  logic             MEM_BUSYWAIT,
  input  logic             IMEM_BUSYWAIT,
  output logic             PC_HOLD,
  output logic             IFID_HOLD,
  output logic             IFID_FLUSH,
  output logic             IDEX_HOLD,
  output logic             IDEX_FLUSH,
  output logic             EXMEM_BUBBLE,
  output logic             MDU_START,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  state_t state, state_nxt;
  logic   freeze;
  logic   load_use;

  assign freeze   = MEM_BUSYWAIT | IMEM_BUSYWAIT;
  assign load_use = MEMREAD_IDEX && (RD_IDEX != 5'd0) &&
                    ((RS1_USE_ID && (RS1_ID == RD_IDEX)) ||
                     (RS2_USE_ID && (RS2_ID == RD_IDEX)));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      state <= RUN;
    else
      state <= state_nxt;
  end

  // A frozen pipe keeps every hazard in place, so the FSM simply waits.
  always_comb begin
    state_nxt = state;
    if (!freeze) begin
      case (state)
        RUN:      if (!BRANCH_TAKEN_EX && MDU_OP_IDEX) state_nxt = MDU_WAIT;
        MDU_WAIT: if (MDU_DONE)                        state_nxt = RUN;
        default:  state_nxt = RUN;
      endcase
    end
  end

  // Outputs are gated by RESET so an in-flight MDU wait releases immediately.
  always_comb begin
    PC_HOLD      = 1'b0;
    IFID_HOLD    = 1'b0;
    IFID_FLUSH   = 1'b0;
    IDEX_HOLD    = 1'b0;
    IDEX_FLUSH   = 1'b0;
    EXMEM_BUBBLE = 1'b0;
    MDU_START    = 1'b0;
    if (!RESET) begin
      if (freeze) begin
        PC_HOLD   = 1'b1;
        IFID_HOLD = 1'b1;
        IDEX_HOLD = 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (BRANCH_TAKEN_EX) begin
              IFID_FLUSH = 1'b1;
              IDEX_FLUSH = 1'b1;
            end else if (MDU_OP_IDEX) begin
              MDU_START    = 1'b1;
              PC_HOLD      = 1'b1;
              IFID_HOLD    = 1'b1;
              IDEX_HOLD    = 1'b1;
              EXMEM_BUBBLE = 1'b1;
            end else if (load_use) begin
              PC_HOLD    = 1'b1;
              IFID_HOLD  = 1'b1;
              IDEX_FLUSH = 1'b1;
            end
          end
          MDU_WAIT: begin
            if (!MDU_DONE) begin
              PC_HOLD      = 1'b1;
              IFID_HOLD    = 1'b1;
              IDEX_HOLD    = 1'b1;
              EXMEM_BUBBLE = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (PC_HOLD),
    .COUNT (STALL_CNT)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (IFID_FLUSH),
    .COUNT (FLUSH_CNT)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a 4-bit counter width so
// saturation is reachable quickly.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             CLK;
  logic             RESET;
  logic [4:0]       RS1_ID, RS2_ID, RD_IDEX;
  logic             RS1_USE_ID, RS2_USE_ID, MEMREAD_IDEX, BRANCH_TAKEN_EX;
  logic             MDU_OP_IDEX, MDU_DONE, MEM_BUSYWAIT, IMEM_BUSYWAIT;
  logic             PC_HOLD, IFID_HOLD, IFID_FLUSH, IDEX_HOLD, IDEX_FLUSH;
  logic             EXMEM_BUBBLE, MDU_START;
  logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;

  int n_checks = 0;
  int n_err    = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .RS1_ID          (RS1_ID),
    .RS2_ID          (RS2_ID),
    .RS1_USE_ID      (RS1_USE_ID),
    .RS2_USE_ID      (RS2_USE_ID),
    .RD_IDEX         (RD_IDEX),
    .MEMREAD_IDEX    (MEMREAD_IDEX),
    .BRANCH_TAKEN_EX (BRANCH_TAKEN_EX),
    .MDU_OP_IDEX     (MDU_OP_IDEX),
    .MDU_DONE        (MDU_DONE),
    .MEM_BUSYWAIT    (MEM_BUSYWAIT),
    .IMEM_BUSYWAIT   (IMEM_BUSYWAIT),
    .PC_HOLD         (PC_HOLD),
    .IFID_HOLD       (IFID_HOLD),
    .IFID_FLUSH      (IFID_FLUSH),
    .IDEX_HOLD       (IDEX_HOLD),
    .IDEX_FLUSH      (IDEX_FLUSH),
    .EXMEM_BUBBLE    (EXMEM_BUBBLE),
    .MDU_START       (MDU_START),
    .STALL_CNT       (STALL_CNT),
    .FLUSH_CNT       (FLUSH_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {PC_HOLD, IFID_HOLD, IFID_FLUSH, IDEX_HOLD, IDEX_FLUSH, EXMEM_BUBBLE, MDU_START}
  logic [6:0] outs;
  assign outs = {PC_HOLD, IFID_HOLD, IFID_FLUSH, IDEX_HOLD, IDEX_FLUSH,
                 EXMEM_BUBBLE, MDU_START};

  localparam logic [6:0] O_IDLE  = 7'b000_0000;
  localparam logic [6:0] O_LDUSE = 7'b110_0100;
  localparam logic [6:0] O_BR    = 7'b001_0100;
  localparam logic [6:0] O_MDUGO = 7'b110_1011;
  localparam logic [6:0] O_MDUWT = 7'b110_1010;
  localparam logic [6:0] O_FRZ   = 7'b110_1000;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RS1_ID = 5'd0; RS2_ID = 5'd0; RD_IDEX = 5'd0;
    RS1_USE_ID = 1'b0; RS2_USE_ID = 1'b0; MEMREAD_IDEX = 1'b0;
    BRANCH_TAKEN_EX = 1'b0; MDU_OP_IDEX = 1'b0; MDU_DONE = 1'b0;
    MEM_BUSYWAIT = 1'b0; IMEM_BUSYWAIT = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    RESET = 1'b1;
    #1;
    chk("rst_outs", {9'd0, outs}, {9'd0, O_IDLE});
    chk("rst_stall", {12'd0, STALL_CNT}, 16'd0);
    chk("rst_flush", {12'd0, FLUSH_CNT}, 16'd0);
    RESET = 1'b0;
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    clear_inputs();
    #1;
    chk("reset_outs", {9'd0, outs}, {9'd0, O_IDLE});
    tick();
    chk("reset_stall", {12'd0, STALL_CNT}, 16'd0);
    chk("reset_flush", {12'd0, FLUSH_CNT}, 16'd0);
    RESET = 1'b0;
    tick();
    chk("run_idle", {9'd0, outs}, {9'd0, O_IDLE});

    // Load-use on rs1
    MEMREAD_IDEX = 1'b1; RD_IDEX = 5'd5; RS1_ID = 5'd5; RS1_USE_ID = 1'b1;
    #1;
    chk("lu_rs1", {9'd0, outs}, {9'd0, O_LDUSE});
    tick();
    clear_inputs();
    #1;
    chk("lu_after", {9'd0, outs}, {9'd0, O_IDLE});
    chk("lu_stall_cnt", {12'd0, STALL_CNT}, 16'd1);
    chk("lu_flush_cnt", {12'd0, FLUSH_CNT}, 16'd0);

    // rd = x0 and unused rs2 never stall; used rs2 does
    MEMREAD_IDEX = 1'b1; RD_IDEX = 5'd0; RS1_ID = 5'd0; RS1_USE_ID = 1'b1;
    #1;
    chk("lu_x0", {9'd0, outs}, {9'd0, O_IDLE});
    RD_IDEX = 5'd7; RS1_ID = 5'd3; RS2_ID = 5'd7; RS2_USE_ID = 1'b0;
    #1;
    chk("lu_rs2_unused", {9'd0, outs}, {9'd0, O_IDLE});
    RS2_USE_ID = 1'b1;
    #1;
    chk("lu_rs2_used", {9'd0, outs}, {9'd0, O_LDUSE});
    tick();
    clear_inputs();
    #1;
    chk("lu_rs2_cnt", {12'd0, STALL_CNT}, 16'd2);

    // Branch wins over a simultaneous load-use
    pulse_reset();
    BRANCH_TAKEN_EX = 1'b1;
    MEMREAD_IDEX = 1'b1; RD_IDEX = 5'd5; RS1_ID = 5'd5; RS1_USE_ID = 1'b1;
    #1;
    chk("br_lu", {9'd0, outs}, {9'd0, O_BR});
    tick();
    clear_inputs();
    #1;
    chk("br_after", {9'd0, outs}, {9'd0, O_IDLE});
    chk("br_flush_cnt", {12'd0, FLUSH_CNT}, 16'd1);
    chk("br_stall_cnt", {12'd0, STALL_CNT}, 16'd0);

    // MDU op, DONE arriving after 8 wait cycles
    pulse_reset();
    MDU_OP_IDEX = 1'b1;
    #1;
    chk("mdu_start", {9'd0, outs}, {9'd0, O_MDUGO});
    tick();
    for (int i = 0; i < 8; i++) begin
      BRANCH_TAKEN_EX = (i == 3);
      #1;
      chk($sformatf("mdu_wait%0d", i), {9'd0, outs}, {9'd0, O_MDUWT});
      tick();
    end
    BRANCH_TAKEN_EX = 1'b0;
    MDU_DONE = 1'b1;
    #1;
    chk("mdu_done", {9'd0, outs}, {9'd0, O_IDLE});
    tick();
    clear_inputs();
    #1;
    chk("mdu_stall_cnt", {12'd0, STALL_CNT}, 16'd9);
    MDU_DONE = 1'b1;
    #1;
    chk("mdu_done_in_run", {9'd0, outs}, {9'd0, O_IDLE});
    tick();
    clear_inputs();
    #1;
    chk("mdu_run_state", {9'd0, outs}, {9'd0, O_IDLE});

    // Memory freeze holds a pending branch, then it flushes
    pulse_reset();
    BRANCH_TAKEN_EX = 1'b1;
    for (int i = 0; i < 3; i++) begin
      MEM_BUSYWAIT  = (i != 1);
      IMEM_BUSYWAIT = (i == 1);
      #1;
      chk($sformatf("frz%0d", i), {9'd0, outs}, {9'd0, O_FRZ});
      tick();
    end
    MEM_BUSYWAIT = 1'b0; IMEM_BUSYWAIT = 1'b0;
    #1;
    chk("frz_release_br", {9'd0, outs}, {9'd0, O_BR});
    tick();
    clear_inputs();
    #1;
    chk("frz_stall_cnt", {12'd0, STALL_CNT}, 16'd3);
    chk("frz_flush_cnt", {12'd0, FLUSH_CNT}, 16'd1);

    // Reset asserted while waiting on the MDU
    MDU_OP_IDEX = 1'b1;
    tick();
    tick();
    chk("mdu_pre_rst", {9'd0, outs}, {9'd0, O_MDUWT});
    RESET = 1'b1;
    #1;
    chk("mdu_rst_async", {9'd0, outs}, {9'd0, O_IDLE});
    MDU_OP_IDEX = 1'b0;
    RESET = 1'b0;
    #1;
    chk("mdu_rst_run", {9'd0, outs}, {9'd0, O_IDLE});
    tick();
    chk("mdu_rst_stays", {9'd0, outs}, {9'd0, O_IDLE});

    // Saturation of the 4-bit stall counter
    pulse_reset();
    MEM_BUSYWAIT = 1'b1;
    repeat (15) tick();
    chk("sat_reach", {12'd0, STALL_CNT}, 16'd15);
    repeat (3) tick();
    chk("sat_hold", {12'd0, STALL_CNT}, 16'd15);
    clear_inputs();
    tick();
    chk("sat_idle", {12'd0, STALL_CNT}, 16'd15);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
